iir_biquad_mc: RTL and testbench
================================

# iir_biquad_mc

Parametrised multi-channel second-order IIR section (Direct Form I biquad) with run-time programmable coefficients, valid/ready handshakes on input and output, and per-channel filter history. A single shared multiplier is time-multiplexed over the five taps by a small FSM. It is the next-generation filter stage of the DSP datapath, replacing the fixed-gain first-order filter, and sits between sample producers and downstream DSP stages.

## Interface
- DW, 16: sample width, signed two's complement
- CW, 16: coefficient width, signed
- FRAC, 14: coefficient fraction bits (default Q2.14)
- NCH, 2: number of channels; CHW = (NCH>1) ? $clog2(NCH) : 1
- clk  in  1  clock; all logic on posedge
- rst_n  in  1  reset; one clock, reset asynchronous and active-low
- coef_we  in  1  coefficient write strobe
- coef_sel  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5–7 ignored
- coef_data  in  CW  coefficient value
- in_valid / in_ready  in / out  1  input handshake
- in_ch  in  CHW  channel of input sample
- in_data  in  DW  input sample x[n]
- out_valid / out_ready  out / in  1  output handshake
- out_ch  out  CHW  channel of result
- out_data  out  DW  result y[n]

## Operation
- y[n] = (b0·x[n] + b1·x[n-1] + b2·x[n-2] − a1·y[n-1] − a2·y[n-2] + 2^(FRAC-1)) >>> FRAC, i.e. round half up, arithmetic shift.
- Products are DW+CW bits, signed. The accumulator is ACCW = DW+CW+3 bits, signed, and never overflows internally.
- Per-channel history registers x1, x2, y1, y2 reset to 0.
- On result: x2←x1, x1←x, y2←y1, y1←stored y. The stored y is the same value driven on out_data, after saturation or wrap.
- Coefficient registers are writable at any time.
  - Reset values: b0 = 1<<FRAC, all others 0, which gives passthrough.
  - A shadow copy is taken on each input accept, so a write during computation affects only later samples.
- FSM states: IDLE, MAC, SAT, OUT.
  - IDLE: in_ready=1. On in_valid: latch x, ch and the coefficient shadow; set acc = 2^(FRAC-1); tap counter = 0; go to MAC.
  - MAC: one product per cycle, taps in order b0, b1, b2, a1, a2. After tap 4, go to SAT.
  - SAT: shift and saturate/wrap; register out_data and out_ch; update history; go to OUT.
  - OUT: out_valid=1. Hold out_data and out_ch stable until out_ready, then go to IDLE.
- in_ready is low in MAC, SAT and OUT.
- in_ch ≥ NCH: the sample is still accepted and processed through the FSM. out_data=0, out_ch echoes in_ch, and no history is updated.
- Reset asserted mid-operation: FSM goes to IDLE, outputs and history take their reset values, and coefficients return to their defaults.

## Timing
- Reset values: in_ready=1, out_valid=0, out_ch=0, out_data=0.
- Input accepted at edge e0; MAC occupies edges e1–e5; SAT completes at e6. out_valid is high from e6, giving a latency of 6 cycles.
- With out_ready=1, the output handshake occurs at e7 and in_ready is high after e7. The next accept is possible at e8, so the initiation interval is 8 cycles.
- A coef_we at the same edge as an accept is not included in that accept's shadow.

## Configuration
- IIR_SAT_EN defined: the result is clamped to [−2^(DW-1), 2^(DW-1)−1].
- IIR_SAT_EN undefined: the result is truncated to the low DW bits (wrap).
- The ports are identical in both builds.

## Structure
- Package iir_pkg holds:
  - state enum (IDLE, MAC, SAT, OUT)
  - coefficient index localparams (COEF_B0 … COEF_A2)
  - coefficient-set struct
  - saturate/round helper function
- Sub-module iir_hist_mem: NCH-entry history storage with one read port and one write port, indexed by channel, with async-reset clear.

## Test plan
- Reset then passthrough: ch0 in 1000 → out_valid 6 cycles after accept, out_data=1000, out_ch=0; in_ready low until the output handshake.
- Load b0=0x2000, a1=0xE000 (y=0.5x+0.5y1); step of 1000 on ch0 → outputs 500, 750, 875.
- Same coefficients with NCH=2, interleaving ch0=1000 and ch1=−2000 → outputs 500, −1000, 750, −1500 (channel histories independent).
- out_ready held low for 10 cycles in OUT → out_valid stays 1, out_data stable, in_ready 0, no second accept; a coef_we issued during this stall does not change the held result.
- b0=0x7FFF, in 30000 → out_data 32767 with IIR_SAT_EN; −5538 without it.
- rst_n pulsed low during MAC → out_valid 0, no output emitted. Next input 1000 → out_data 1000, since coefficients and history are back to defaults.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared types, coefficient indices and the round/saturate helper for iir_biquad_mc.
package iir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        SAT  = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam logic [2:0] COEF_B0 = 3'd0;
    localparam logic [2:0] COEF_B1 = 3'd1;
    localparam logic [2:0] COEF_B2 = 3'd2;
    localparam logic [2:0] COEF_A1 = 3'd3;
    localparam logic [2:0] COEF_A2 = 3'd4;

    // Fields are held sign-extended so any coefficient width up to this fits.
    localparam int COEF_MAXW = 32;

    typedef struct packed {
        logic signed [COEF_MAXW-1:0] b0;
        logic signed [COEF_MAXW-1:0] b1;
        logic signed [COEF_MAXW-1:0] b2;
        logic signed [COEF_MAXW-1:0] a1;
        logic signed [COEF_MAXW-1:0] a2;
    } coef_set_t;

    function automatic logic signed [63:0] shift_sat(
        input logic signed [63:0] acc,
        input int                 frac,
        input int                 dw,
        input bit                 sat_en
    );
        logic signed [63:0] shifted;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        shifted = acc >>> frac;
        hi      = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo      = -(64'sd1 <<< (dw - 1));
        if (sat_en && (shifted > hi)) begin
            shifted = hi;
        end else if (sat_en && (shifted < lo)) begin
            shifted = lo;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/iir_hist_mem.sv
// Per-channel biquad history {x1, x2, y1, y2}: one combinational read port,
// one write port, cleared by the asynchronous reset.
module iir_hist_mem #(
    parameter int DW  = 16,
    parameter int NCH = 2,
    parameter int CHW = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CHW-1:0]  rd_ch,
    output logic [4*DW-1:0] rd_data,
    input  logic            we,
    input  logic [CHW-1:0]  wr_ch,
    input  logic [4*DW-1:0] wr_data
);

    logic [4*DW-1:0] mem [NCH];

    // Channel codes beyond NCH read as empty history.
    always_comb begin
        rd_data = '0;
        if (int'(rd_ch) < NCH) begin
            rd_data = mem[rd_ch];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (int'(wr_ch) < NCH)) begin
            mem[wr_ch] <= wr_data;
        end
    end

endmodule

// File: rtl/iir_biquad_mc.sv
// Multi-channel Direct Form I biquad with one time-shared multiplier.
// Define IIR_SAT_EN to clamp results to the sample range; otherwise they wrap.
module iir_biquad_mc
    import iir_pkg::*;
#(
    parameter int DW   = 16,
    parameter int CW   = 16,
    parameter int FRAC = 14,
    parameter int NCH  = 2,
    parameter int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 coef_we,
    input  logic [2:0]           coef_sel,
    input  logic [CW-1:0]        coef_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CHW-1:0]       in_ch,
    input  logic [DW-1:0]        in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CHW-1:0]       out_ch,
    output logic [DW-1:0]        out_data
);

    localparam int PW   = DW + CW;
    localparam int ACCW = DW + CW + 3;

`ifdef IIR_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic signed [ACCW-1:0] ROUND   = ACCW'(1) << (FRAC - 1);
    localparam logic signed [CW-1:0]   UNITY   = CW'(1) << FRAC;
    localparam coef_set_t COEF_RESET = '{
        b0: COEF_MAXW'(UNITY),
        b1: '0,
        b2: '0,
        a1: '0,
        a2: '0
    };

    state_t                 state;
    state_t                 next_state;
    logic                   accept;
    logic                   mac_step;
    logic                   sat_step;

    coef_set_t              coef;
    coef_set_t              shadow;
    logic signed [DW-1:0]   x_cur;
    logic [CHW-1:0]         ch_cur;
    logic [2:0]             tap;
    logic signed [ACCW-1:0] acc;

    logic [4*DW-1:0]        hist_rd;
    logic [4*DW-1:0]        hist_wr;
    logic signed [DW-1:0]   h_x1;
    logic signed [DW-1:0]   h_x2;
    logic signed [DW-1:0]   h_y1;
    logic signed [DW-1:0]   h_y2;
    logic                   ch_ok;

    logic signed [DW-1:0]        op_data;
    logic signed [COEF_MAXW-1:0] op_coef;
    logic                        op_sub;
    logic signed [PW-1:0]        product;
    logic signed [DW-1:0]        y_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        mac_step   = 1'b0;
        sat_step   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    next_state = MAC;
                end
            end
            MAC: begin
                mac_step = 1'b1;
                if (tap == 3'd4) begin
                    next_state = SAT;
                end
            end
            SAT: begin
                sat_step   = 1'b1;
                next_state = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef <= COEF_RESET;
        end else if (coef_we) begin
            case (coef_sel)
                COEF_B0: coef.b0 <= COEF_MAXW'(signed'(coef_data));
                COEF_B1: coef.b1 <= COEF_MAXW'(signed'(coef_data));
                COEF_B2: coef.b2 <= COEF_MAXW'(signed'(coef_data));
                COEF_A1: coef.a1 <= COEF_MAXW'(signed'(coef_data));
                COEF_A2: coef.a2 <= COEF_MAXW'(signed'(coef_data));
                default: ;
            endcase
        end
    end

    iir_hist_mem #(
        .DW  (DW),
        .NCH (NCH),
        .CHW (CHW)
    ) u_hist (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_ch   (ch_cur),
        .rd_data (hist_rd),
        .we      (sat_step && ch_ok),
        .wr_ch   (ch_cur),
        .wr_data (hist_wr)
    );

    assign {h_x1, h_x2, h_y1, h_y2} = hist_rd;
    assign ch_ok = (int'(ch_cur) < NCH);

    always_comb begin
        op_data = '0;
        op_coef = '0;
        op_sub  = 1'b0;
        case (tap)
            3'd0: begin op_data = x_cur; op_coef = shadow.b0; end
            3'd1: begin op_data = h_x1;  op_coef = shadow.b1; end
            3'd2: begin op_data = h_x2;  op_coef = shadow.b2; end
            3'd3: begin op_data = h_y1;  op_coef = shadow.a1; op_sub = 1'b1; end
            3'd4: begin op_data = h_y2;  op_coef = shadow.a2; op_sub = 1'b1; end
            default: ;
        endcase
    end

    // Coefficients fit in CW bits, so truncating the sign-extended field is exact.
    assign product = PW'(op_data) * PW'(op_coef);

    assign y_res   = DW'(shift_sat(64'(acc), FRAC, DW, SAT_EN));
    assign hist_wr = {x_cur, h_x1, y_res, h_y1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cur    <= '0;
            ch_cur   <= '0;
            tap      <= '0;
            acc      <= '0;
            shadow   <= COEF_RESET;
            out_data <= '0;
            out_ch   <= '0;
        end else begin
            if (accept) begin
                x_cur  <= signed'(in_data);
                ch_cur <= in_ch;
                shadow <= coef;
                acc    <= ROUND;
                tap    <= '0;
            end
            if (mac_step) begin
                acc <= op_sub ? (acc - ACCW'(product)) : (acc + ACCW'(product));
                tap <= tap + 3'd1;
            end
            if (sat_step) begin
                out_data <= ch_ok ? y_res : '0;
                out_ch   <= ch_cur;
            end
        end
    end

endmodule

// File: tb/tb_iir_biquad_mc.sv
// Randomised self-checking bench for iir_biquad_mc against an arithmetic biquad model.
// Compile with IIR_SAT_EN defined to check the saturating build.
module tb_iir_biquad_mc;

    localparam int DW   = 16;
    localparam int CW   = 16;
    localparam int FRAC = 14;
    localparam int NCH  = 3;
    localparam int CHW  = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           coef_we = 1'b0;
    logic [2:0]     coef_sel = '0;
    logic [CW-1:0]  coef_data = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [CHW-1:0] in_ch = '0;
    logic [DW-1:0]  in_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [CHW-1:0] out_ch;
    logic [DW-1:0]  out_data;

    int checks = 0;
    int errors = 0;

    // Model state: live coefficients and per-channel history as plain integers.
    int coef_m [5];
    int xh1 [NCH];
    int xh2 [NCH];
    int yh1 [NCH];
    int yh2 [NCH];
    int last_y;

    bit          pending_we = 1'b0;
    logic [2:0]  pending_sel = '0;
    logic [CW-1:0] pending_data = '0;

    always #5 clk = ~clk;

    iir_biquad_mc #(
        .DW   (DW),
        .CW   (CW),
        .FRAC (FRAC),
        .NCH  (NCH),
        .CHW  (CHW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .coef_we   (coef_we),
        .coef_sel  (coef_sel),
        .coef_data (coef_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_data  (out_data)
    );

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int toCoef(input logic [CW-1:0] d);
        logic signed [CW-1:0] s;
        s = d;
        return int'(s);
    endfunction

    function automatic int toSample(input logic [DW-1:0] d);
        logic signed [DW-1:0] s;
        s = d;
        return int'(s);
    endfunction

    function automatic int fitOutput(input longint v);
        longint m;
        longint w;
        m = longint'(1) << DW;
`ifdef IIR_SAT_EN
        if (v > (m / 2) - 1) return int'((m / 2) - 1);
        if (v < -(m / 2))    return int'(-(m / 2));
        return int'(v);
`else
        w = v % m;
        if (w < 0) w += m;
        if (w >= m / 2) w -= m;
        return int'(w);
`endif
    endfunction

    task automatic modelReset();
        coef_m[0] = 1 << FRAC;
        for (int i = 1; i < 5; i++) coef_m[i] = 0;
        for (int c = 0; c < NCH; c++) begin
            xh1[c] = 0; xh2[c] = 0; yh1[c] = 0; yh2[c] = 0;
        end
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        modelReset();
    endtask

    task automatic writeCoef(input logic [2:0] sel, input logic [CW-1:0] data);
        coef_we = 1'b1; coef_sel = sel; coef_data = data;
        @(posedge clk); #1;
        coef_we = 1'b0;
        if (sel < 3'd5) coef_m[sel] = toCoef(data);
    endtask

    // Sends one sample, waits for its result and checks latency, value and handshakes.
    task automatic applyStimulus(input int ch, input int x, input int stall);
        int     sh [5];
        int     lat;
        bit     early;
        bit     bad;
        longint acc;
        int     exp_y;
        logic [DW-1:0] held;
        logic [CHW-1:0] chv;
        logic [DW-1:0]  xv;
        chv = CHW'(ch);
        xv  = DW'(x);
        checkOutput("in_ready_idle", longint'(in_ready), 1);
        sh = coef_m;
        in_valid = 1'b1; in_ch = chv; in_data = xv;
        if (pending_we) begin
            coef_we = 1'b1; coef_sel = pending_sel; coef_data = pending_data;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (pending_we) begin
            coef_we = 1'b0;
            if (pending_sel < 3'd5) coef_m[pending_sel] = toCoef(pending_data);
            pending_we = 1'b0;
        end
        lat = 0; early = 1'b0;
        while (!out_valid && lat < 20) begin
            if (in_ready) early = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("latency", lat, 6);
        if (!out_valid) return;
        checkOutput("busy_in_ready", longint'(early), 0);

        acc = longint'(sh[0]) * x;
        if (ch < NCH) begin
            acc += longint'(sh[1]) * xh1[ch] + longint'(sh[2]) * xh2[ch]
                 - longint'(sh[3]) * yh1[ch] - longint'(sh[4]) * yh2[ch];
        end
        acc += longint'(1) << (FRAC - 1);
        exp_y = (ch < NCH) ? fitOutput(acc >>> FRAC) : 0;
        checkOutput("out_data", longint'(toSample(out_data)), exp_y);
        checkOutput("out_ch", longint'(out_ch), ch);
        last_y = toSample(out_data);

        if (stall > 0) begin
            out_ready = 1'b0;
            held = out_data;
            bad = 1'b0;
            in_valid = 1'b1; in_ch = '0; in_data = DW'(77);
            coef_we = 1'b1; coef_sel = 3'($urandom_range(0, 4)); coef_data = CW'($urandom_range(0, 8191));
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                if (coef_we) begin
                    coef_we = 1'b0;
                    coef_m[coef_sel] = toCoef(coef_data);
                end
                if (!out_valid || out_data !== held || in_ready) bad = 1'b1;
            end
            in_valid = 1'b0;
            checkOutput("stall_hold", longint'(bad), 0);
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        checkOutput("post_handshake", longint'({out_valid, in_ready}), 1);

        if (ch < NCH) begin
            xh2[ch] = xh1[ch]; xh1[ch] = x;
            yh2[ch] = yh1[ch]; yh1[ch] = exp_y;
        end
    endtask

    initial begin
        int ch;
        int x;
        int stall;
        int lat;
        bit seen;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", longint'(in_ready), 1);
        checkOutput("reset_out_valid", longint'(out_valid), 0);
        checkOutput("reset_out_ch", longint'(out_ch), 0);
        checkOutput("reset_out_data", longint'(out_data), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] passthrough");
        applyStimulus(0, 1000, 0);
        checkOutput("passthrough_const", last_y, 1000);

        $display("[TB] first-order step");
        resetDut();
        writeCoef(3'd0, 16'h2000);
        writeCoef(3'd3, 16'hE000);
        applyStimulus(0, 1000, 0);
        checkOutput("step0_const", last_y, 500);
        applyStimulus(0, 1000, 0);
        checkOutput("step1_const", last_y, 750);
        applyStimulus(0, 1000, 0);
        checkOutput("step2_const", last_y, 875);

        $display("[TB] interleaved channels");
        resetDut();
        writeCoef(3'd0, 16'h2000);
        writeCoef(3'd3, 16'hE000);
        applyStimulus(0, 1000, 0);
        applyStimulus(1, -2000, 0);
        checkOutput("ch1_first_const", last_y, -1000);
        applyStimulus(0, 1000, 0);
        checkOutput("ch0_second_const", last_y, 750);
        applyStimulus(1, -2000, 10);
        checkOutput("ch1_second_const", last_y, -1500);

        $display("[TB] invalid channel and same-edge coefficient write");
        applyStimulus(3, 1234, 0);
        pending_we = 1'b1; pending_sel = 3'd0; pending_data = 16'h1000;
        applyStimulus(0, 4000, 0);
        applyStimulus(0, 4000, 0);

        $display("[TB] saturation boundary");
        resetDut();
        writeCoef(3'd0, 16'h7FFF);
        applyStimulus(0, 30000, 0);
`ifdef IIR_SAT_EN
        checkOutput("sat_const", last_y, 32767);
`else
        checkOutput("wrap_const", last_y, -5538);
`endif

        $display("[TB] reset during MAC");
        in_valid = 1'b1; in_ch = '0; in_data = DW'(500);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        checkOutput("midreset_out_valid", longint'(out_valid), 0);
        checkOutput("midreset_in_ready", longint'(in_ready), 1);
        checkOutput("midreset_out_data", longint'(out_data), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        modelReset();
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checkOutput("midreset_no_output", longint'(seen), 0);
        applyStimulus(0, 1000, 0);
        checkOutput("midreset_passthrough", last_y, 1000);

        $display("[TB] randomised traffic");
        writeCoef(3'd0, 16'h1800);
        writeCoef(3'd1, 16'h0C00);
        writeCoef(3'd3, 16'hD000);
        writeCoef(3'd4, 16'h0800);
        for (int n = 0; n < 40; n++) begin
            ch    = int'($urandom_range(0, 3));
            x     = toSample(DW'($urandom));
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            if ($urandom_range(0, 4) == 0) begin
                pending_we   = 1'b1;
                pending_sel  = 3'($urandom_range(0, 7));
                pending_data = CW'($urandom);
            end
            applyStimulus(ch, x, stall);
            lat = int'($urandom_range(0, 2));
            repeat (lat) begin
                @(posedge clk); #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
